// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit teaching processor: control states,
// opcodes and ALU function selects used by the controller, ALU and datapath.
package proc_pkg;

   typedef enum logic [3:0] {
      INIT   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      LOAD_A = 4'd3,
      LOAD_B = 4'd4,
      STORE  = 4'd5,
      ADD    = 4'd6,
      SUB    = 4'd7,
      HALT   = 4'd8,
      NOOP   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_LOAD  = 4'd1;
   localparam logic [3:0] OP_STORE = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/proc_control_fsm.sv
// Control unit for the teaching processor: fetch/decode/execute sequencer
// with Moore-decoded datapath controls and exported state for debug display.
module proc_control_fsm
   import proc_pkg::*;
#(
   parameter int IW   = 16,
   parameter int DA_W = 8,
   parameter int RA_W = 4
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic [IW-1:0]   IR,
   output logic            PC_Clr,
   output logic            PC_Up,
   output logic            IR_Ld,
   output logic [DA_W-1:0] D_Addr,
   output logic            D_Wr,
   output logic            RF_s,
   output logic [RA_W-1:0] RF_W_addr,
   output logic            RF_W_en,
   output logic [RA_W-1:0] RF_Ra_addr,
   output logic [RA_W-1:0] RF_Rb_addr,
   output logic [2:0]      ALU_s0,
   output logic [3:0]      State,
   output logic [3:0]      NextState
);

   state_t     state;
   state_t     next_state;
   logic [3:0] opcode;

   // IR field layout: [opcode | ra/mem-hi | rb/mem-lo | rd]
   assign opcode    = IR[IW-1 -: 4];
   assign State     = state;
   assign NextState = next_state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= INIT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = INIT;
      case (state)
         INIT:   next_state = FETCH;
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_LOAD:  next_state = LOAD_A;
               OP_STORE: next_state = STORE;
               OP_ADD:   next_state = ADD;
               OP_SUB:   next_state = SUB;
               OP_HALT:  next_state = HALT;
               default:  next_state = NOOP;
            endcase
         end
         LOAD_A: next_state = LOAD_B;
         LOAD_B: next_state = FETCH;
         STORE:  next_state = FETCH;
         ADD:    next_state = FETCH;
         SUB:    next_state = FETCH;
         NOOP:   next_state = FETCH;
         HALT:   next_state = HALT;
         // Unused encodings recover through INIT
         default: next_state = INIT;
      endcase
   end

   always_comb begin
      PC_Clr     = 1'b0;
      PC_Up      = 1'b0;
      IR_Ld      = 1'b0;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = ALU_PASS;
      case (state)
         INIT: PC_Clr = 1'b1;
         FETCH: begin
            PC_Up = 1'b1;
            IR_Ld = 1'b1;
         end
         // LOAD_A presents the address so the synchronous RAM data is ready in LOAD_B
         LOAD_A: D_Addr = IR[IW-5 -: DA_W];
         LOAD_B: begin
            D_Addr    = IR[IW-5 -: DA_W];
            RF_s      = 1'b1;
            RF_W_addr = IR[RA_W-1:0];
            RF_W_en   = 1'b1;
         end
         STORE: begin
            RF_Ra_addr = IR[IW-5 -: RA_W];
            D_Addr     = IR[DA_W-1:0];
            D_Wr       = 1'b1;
            ALU_s0     = ALU_PASS;
         end
         ADD, SUB: begin
            RF_Ra_addr = IR[IW-5 -: RA_W];
            RF_Rb_addr = IR[IW-9 -: RA_W];
            RF_W_addr  = IR[RA_W-1:0];
            RF_W_en    = 1'b1;
            ALU_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: an instruction-level model queues the
// expected per-cycle control word; a negedge monitor pops and compares.
module tb_proc_control_fsm;

   typedef struct packed {
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] rf_w_addr;
      logic       rf_w_en;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic [3:0] st;
      logic [3:0] nx;
   } obs_t;

   logic        Clk = 1'b0;
   logic        Reset_n = 1'b0;
   logic [15:0] IR = '0;
   logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_en;
   logic [7:0]  D_Addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State, NextState;
   logic [2:0]  ALU_s0;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;
   obs_t exp_q[$];

   proc_control_fsm dut (
      .Clk(Clk), .Reset_n(Reset_n), .IR(IR),
      .PC_Clr(PC_Clr), .PC_Up(PC_Up), .IR_Ld(IR_Ld),
      .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
      .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
      .ALU_s0(ALU_s0), .State(State), .NextState(NextState)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   // Control word the spec's state table requires for state s holding ir
   function automatic obs_t expect_word(input int s, input logic [15:0] ir, input int nx);
      obs_t o = '0;
      o.st = 4'(s);
      o.nx = 4'(nx);
      case (s)
         0: o.pc_clr = 1'b1;
         1: begin o.pc_up = 1'b1; o.ir_ld = 1'b1; end
         3: o.d_addr = ir[11:4];
         4: begin
            o.d_addr = ir[11:4]; o.rf_s = 1'b1; o.rf_w_addr = ir[3:0]; o.rf_w_en = 1'b1;
         end
         5: begin o.ra = ir[11:8]; o.d_addr = ir[7:0]; o.d_wr = 1'b1; end
         6, 7: begin
            o.ra = ir[11:8]; o.rb = ir[7:4]; o.rf_w_addr = ir[3:0]; o.rf_w_en = 1'b1;
            o.alu = (s == 6) ? 3'd1 : 3'd2;
         end
         default: ;
      endcase
      return o;
   endfunction

   // Called at posedge+1: drive IR for this cycle and queue what must be seen
   task automatic step(input int s, input logic [15:0] ir, input int nx);
      IR = ir;
      exp_q.push_back(expect_word(s, ir, nx));
      @(posedge Clk);
      #1;
   endtask

   // One instruction from FETCH to the last execute state
   task automatic run_instr(input logic [15:0] ir);
      int seq[$];
      case (ir[15:12])
         4'd1: seq = '{3, 4};
         4'd2: seq = '{5};
         4'd3: seq = '{6};
         4'd4: seq = '{7};
         4'd5: seq = '{8};
         default: seq = '{9};
      endcase
      step(1, ir, 2);
      step(2, ir, seq[0]);
      for (int i = 0; i < seq.size(); i++)
         step(seq[i], ir, (i + 1 < seq.size()) ? seq[i+1] : ((seq[i] == 8) ? 8 : 1));
   endtask

   always @(negedge Clk) begin
      if (mon_en) begin
         obs_t got;
         got = '{PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_addr, RF_W_en,
                 RF_Ra_addr, RF_Rb_addr, ALU_s0, State, NextState};
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_underflow: got state %0d, required queued entry", State);
         end else begin
            obs_t want;
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL ctrl_word st=%0d ir=%h: got %h, required %h", want.st, IR, got, want);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] dir[5];
      logic [3:0]  op;
      dir = '{16'h1A53, 16'h2B42, 16'h3123, 16'h4456, 16'hF123};

      repeat (2) @(posedge Clk);
      #1;
      check("reset_state", 32'(State), 32'd0);
      check("reset_pc_clr", 32'(PC_Clr), 32'd1);
      check("reset_next", 32'(NextState), 32'd1);
      Reset_n = 1'b1;
      mon_en  = 1'b1;
      step(0, 16'h0000, 1);

      foreach (dir[i]) run_instr(dir[i]);
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'd5) op = 4'hE;
         run_instr({op, 12'($urandom)});
      end

      // Async reset while the LOAD_B register write is pending
      step(1, 16'h1A53, 2);
      step(2, 16'h1A53, 3);
      step(3, 16'h1A53, 4);
      mon_en = 1'b0;
      check("loadb_state", 32'(State), 32'd4);
      check("loadb_wen", 32'(RF_W_en), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("async_state", 32'(State), 32'd0);
      check("async_wen", 32'(RF_W_en), 32'd0);
      check("async_pc_clr", 32'(PC_Clr), 32'd1);
      @(posedge Clk);
      #1 Reset_n = 1'b1;
      check("release_state", 32'(State), 32'd0);
      check("release_next", 32'(NextState), 32'd1);
      check("queue_drained_pre", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      mon_en = 1'b1;
      step(0, 16'h1A53, 1);

      run_instr(16'h3123);
      run_instr(16'h5000);
      repeat (10) step(8, 16'h5000, 8);
      mon_en = 1'b0;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
